// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared types and constants for the multdiv unit
package multdiv_pkg;

  localparam int DIV_WIDTH = 32;
  localparam logic [DIV_WIDTH-1:0] MOST_NEG = {1'b1, {(DIV_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_FIX,
    DIV_DONE
  } div_state_e;

endpackage

// File: rtl/div_iter_counter.sv
// rtl/div_iter_counter.sv - iteration counter with clear, enable and terminal flag
module div_iter_counter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic term_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_o = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/nonrestoring_divider.sv
// rtl/nonrestoring_divider.sv - sequential signed radix-2 non-restoring divider
module nonrestoring_divider
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_q;
  logic [WIDTH:0]   r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic             sq_q;
  logic             sr_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] rem_q;
  logic             exc_q;
  logic             rdy_q;
  logic             term;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             fast_exc;
  logic [WIDTH:0]   d_ext;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   r_d;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH:0]   r_fix;

  // The most-negative dividend negates to itself, which reads correctly as unsigned 2^(WIDTH-1).
  assign abs_a    = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign abs_b    = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  assign fast_exc = (data_operandB == '0) ||
                    ((data_operandA == MIN_VAL) && (data_operandB == '1));

  assign d_ext   = {1'b0, d_q};
  assign r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign r_d     = r_q[WIDTH] ? (r_shift + d_ext) : (r_shift - d_ext);
  assign q_d     = {q_q[WIDTH-2:0], ~r_d[WIDTH]};
  assign r_fix   = r_q[WIDTH] ? (r_q + d_ext) : r_q;

  div_iter_counter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (ctrl_div),
    .en_i  (state_q == DIV_RUN),
    .term_o(term)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= DIV_IDLE;
      r_q      <= '0;
      q_q      <= '0;
      d_q      <= '0;
      sq_q     <= 1'b0;
      sr_q     <= 1'b0;
      result_q <= '0;
      rem_q    <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else if (ctrl_div) begin
      // A start in any state, including mid-operation, discards the current op.
      if (fast_exc) begin
        state_q  <= DIV_DONE;
        result_q <= '0;
        rem_q    <= '0;
        exc_q    <= 1'b1;
        rdy_q    <= 1'b1;
      end else begin
        state_q <= DIV_RUN;
        d_q     <= abs_b;
        q_q     <= abs_a;
        r_q     <= '0;
        sq_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        sr_q    <= data_operandA[WIDTH-1];
        exc_q   <= 1'b0;
        rdy_q   <= 1'b0;
      end
    end else begin
      case (state_q)
        DIV_RUN: begin
          r_q <= r_d;
          q_q <= q_d;
          if (term) begin
            state_q <= DIV_FIX;
          end
        end
        DIV_FIX: begin
          r_q      <= r_fix;
          result_q <= sq_q ? -q_q : q_q;
          rem_q    <= sr_q ? -r_fix[WIDTH-1:0] : r_fix[WIDTH-1:0];
          exc_q    <= 1'b0;
          rdy_q    <= 1'b1;
          state_q  <= DIV_DONE;
        end
        DIV_DONE: begin
          rdy_q   <= 1'b0;
          state_q <= DIV_IDLE;
        end
        default: begin
          state_q <= DIV_IDLE;
        end
      endcase
    end
  end

  assign data_result    = result_q;
  assign data_remainder = rem_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_nonrestoring_divider.sv
// tb/tb_nonrestoring_divider.sv - scoreboard bench for nonrestoring_divider
module tb_nonrestoring_divider;
  import multdiv_pkg::*;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         ctrl_div = 1'b0;
  logic [W-1:0] data_operandA = '0;
  logic [W-1:0] data_operandB = '0;
  logic [W-1:0] data_result;
  logic [W-1:0] data_remainder;
  logic         data_exception;
  logic         data_resultRDY;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] rem;
    logic         exc;
    int           at;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  nonrestoring_divider #(.WIDTH(W), .CNT_W(6)) dut (
    .clk           (clk),
    .reset         (reset),
    .ctrl_div      (ctrl_div),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .data_result   (data_result),
    .data_remainder(data_remainder),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic expect_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference via the language's own signed division (truncates toward zero).
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == '0 || (a == MOST_NEG && b == '1)) begin
      e.res = '0; e.rem = '0; e.exc = 1'b1;
    end else begin
      e.res = $signed(a) / $signed(b);
      e.rem = $signed(a) % $signed(b);
      e.exc = 1'b0;
    end
    e.at = 0;
    return e;
  endfunction

  // Caller is aligned to a negedge; returns one negedge later with ctrl_div low.
  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input bit push,
                       input logic [W-1:0] res, input logic [W-1:0] rem, input logic exc);
    exp_t e;
    ctrl_div      = 1'b1;
    data_operandA = a;
    data_operandB = b;
    if (push) begin
      e.res = res; e.rem = rem; e.exc = exc;
      e.at  = edge_cnt + 1 + (exc ? 0 : LAT);
      sb.push_back(e);
    end
    @(negedge clk);
    ctrl_div = 1'b0;
  endtask

  task automatic start_model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e = model(a, b);
    start(a, b, 1'b1, e.res, e.rem, e.exc);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      expect_eq("drain_timeout", W'(sb.size()), '0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && data_resultRDY) begin
      if (sb.size() == 0) begin
        expect_eq("spurious_rdy", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        expect_eq("result", data_result, e.res);
        expect_eq("remainder", data_remainder, e.rem);
        expect_eq("exception", W'(data_exception), W'(e.exc));
        expect_eq("latency", W'(edge_cnt), W'(e.at));
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    expect_eq("rst_result", data_result, '0);
    expect_eq("rst_remainder", data_remainder, '0);
    expect_eq("rst_exception", W'(data_exception), '0);
    expect_eq("rst_rdy", W'(data_resultRDY), '0);

    start(32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0);                 drain();
    start(-32'sd100, 32'd7, 1'b1, 32'hFFFF_FFF2, -32'sd2, 1'b0);      drain();
    start(32'd100, -32'sd7, 1'b1, 32'hFFFF_FFF2, 32'd2, 1'b0);        drain();
    start(-32'sd100, -32'sd7, 1'b1, 32'd14, -32'sd2, 1'b0);           drain();
    start(32'd5, 32'd0, 1'b1, 32'd0, 32'd0, 1'b1);                    drain();
    start(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'd0, 1'b1);    drain();
    start(32'h8000_0000, 32'd1, 1'b1, 32'h8000_0000, 32'd0, 1'b0);    drain();

    // Abort mid-run: only the second op may report.
    start(32'd1000, 32'd3, 1'b0, '0, '0, 1'b0);
    repeat (8) @(negedge clk);
    start(32'd9, 32'd4, 1'b1, 32'd2, 32'd1, 1'b0);                    drain();

    // Reset mid-run clears outputs and suppresses RDY.
    start(32'd50, 32'd5, 1'b0, '0, '0, 1'b0);
    repeat (13) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    expect_eq("midrst_result", data_result, '0);
    expect_eq("midrst_remainder", data_remainder, '0);
    expect_eq("midrst_exception", W'(data_exception), '0);
    expect_eq("midrst_rdy", W'(data_resultRDY), '0);
    repeat (40) @(negedge clk);
    start(32'd50, 32'd5, 1'b1, 32'd10, 32'd0, 1'b0);                  drain();

    // Back-to-back: restart during the RDY cycle.
    start(32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0);
    for (int i = 0; i < 100 && !data_resultRDY; i++) @(negedge clk);
    if (!data_resultRDY) expect_eq("b2b_rdy_timeout", 32'd0, 32'd1);
    start(32'd7, 32'd7, 1'b1, 32'd1, 32'd0, 1'b0);                    drain();

    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] a, b;
      a = $urandom;
      b = $urandom_range(1, 1000);
      if (i[0]) b = -b;
      if (i == 5) a = MOST_NEG;
      start_model(a, b);
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
